// File: rtl/float_relu_backprop.sv
// Streaming ReLU with a matching gradient gate. The forward path applies a
// sign-only ReLU and records one pass bit per element in a mask FIFO; the
// backward path pops those bits in order and zeroes gradients whose forward
// element was negative.
module float_relu_backprop #(
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned FRAC_WIDTH  = 23,
  parameter int unsigned DEPTH       = 16,
  localparam int unsigned FLOAT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fwd_valid,
  output logic                   fwd_ready,
  input  logic [FLOAT_WIDTH-1:0] fwd_in,
  output logic                   fwd_out_valid,
  output logic [FLOAT_WIDTH-1:0] fwd_out,
  input  logic                   bwd_valid,
  output logic                   bwd_ready,
  input  logic [FLOAT_WIDTH-1:0] bwd_grad,
  output logic                   bwd_out_valid,
  output logic [FLOAT_WIDTH-1:0] bwd_out,
  output logic [CNT_W-1:0]       count
);

  logic [DEPTH-1:0]       r_mask;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   r_fwd_out_valid;
  logic [FLOAT_WIDTH-1:0] r_fwd_out;
  logic                   r_bwd_out_valid;
  logic [FLOAT_WIDTH-1:0] r_bwd_out;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_neg;

  // Handshakes look only at the registered count, so there is no same-cycle
  // bypass between push and pop; flush swallows any accept in its cycle.
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_empty = (r_count == '0);
    w_push  = fwd_valid & ~w_full & ~flush;
    w_pop   = bwd_valid & ~w_empty & ~flush;
    w_neg   = fwd_in[FLOAT_WIDTH-1];
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and count state; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Mask storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mask[r_wr_ptr] <= ~w_neg;
  end

  // Forward result register: negatives (including -0, -Inf, -NaN) become +0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_out_valid <= 1'b0;
      r_fwd_out       <= '0;
    end else begin
      r_fwd_out_valid <= w_push;
      if (w_push) r_fwd_out <= w_neg ? '0 : fwd_in;
    end
  end

  // Backward result register: gradient passes only if its mask bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bwd_out_valid <= 1'b0;
      r_bwd_out       <= '0;
    end else begin
      r_bwd_out_valid <= w_pop;
      if (w_pop) r_bwd_out <= r_mask[r_rd_ptr] ? bwd_grad : '0;
    end
  end

  assign fwd_ready     = ~w_full;
  assign bwd_ready     = ~w_empty;
  assign fwd_out_valid = r_fwd_out_valid;
  assign fwd_out       = r_fwd_out;
  assign bwd_out_valid = r_bwd_out_valid;
  assign bwd_out       = r_bwd_out;
  assign count         = r_count;

endmodule
